// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//
// UART receiver. Deserializes 8N1 frames from rx_i and buffers the bytes in a
// small FIFO. The FIFO head is offered to the consumer over a valid/ready
// handshake. Framing and overrun errors are reported as sticky flags.
//
// Optional feature macro: UART_RX_PARITY_EN
//   When defined, the frame is 8E1. A PARITY state is added between DATA and
//   STOP, and a sticky parity_err output is added. A byte whose data bits and
//   parity bit XOR to 1 is discarded at STOP.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit; must be >= 8
//   FIFO_DEPTH    RX FIFO entries; must be a power of 2 and >= 2
//   CNT_W         bit-timing counter width; must hold CLKS_PER_BIT-1
//
// Ports
//   wb_clk_i    in   single clock
//   wb_rst_i    in   synchronous, active-high reset
//   rx_i        in   serial input; idles high
//   rx_data     out  byte at the FIFO head
//   rx_valid    out  FIFO not empty
//   rx_ready    in   head byte is popped when rx_valid && rx_ready
//   rx_level    out  FIFO occupancy
//   frame_err   out  sticky: a stop bit was sampled low
//   overrun     out  sticky: a byte was dropped because the FIFO was full
//   err_clr     in   one-cycle pulse that clears the sticky flags
//   parity_err  out  sticky parity error (only with UART_RX_PARITY_EN)
//   irq         out  equals rx_valid
// -----------------------------------------------------------------------------
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 4167,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 13
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          rx_i,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clr,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    output logic                          irq
);

    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W:0]   LVL_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;
`endif

    // ---------------------------------------------------------------------
    // Input synchronizer and falling-edge detect
    // ---------------------------------------------------------------------
    logic r_sync1;
    logic r_rx_s;
    logic r_rx_d;
    logic w_fall;

    // All three flops reset high so that a reset never creates a false edge.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end

    assign w_fall = r_rx_d & ~r_rx_s;

    // ---------------------------------------------------------------------
    // Receive FSM
    // ---------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             w_half_tick;
    logic             w_bit_tick;
    logic             w_cnt_clr;
    logic             w_shift_en;
    logic             w_push;
    logic             w_frame_set;
`ifdef UART_RX_PARITY_EN
    logic             r_par_bad;
    logic             w_par_set;
`endif

    assign w_half_tick = (r_cnt == HALF_M1);
    assign w_bit_tick  = (r_cnt == FULL_M1);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                // Line back high at mid start bit means a glitch, not a frame.
                if (w_half_tick) begin
                    w_state_nx = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_tick && (r_bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nx = S_PARITY;
`else
                    w_state_nx = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_bit_tick) begin
                    w_state_nx = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Returning straight to IDLE lets a back-to-back start edge
                // be caught without losing a cycle.
                if (w_bit_tick) begin
                    w_state_nx = r_rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                // Wait for the line to go idle so a held-low line cannot
                // produce a stream of bogus frames.
                if (r_rx_s) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_cnt_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_push      = 1'b0;
        w_frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_set   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
            end
            S_START: begin
                w_cnt_clr = w_half_tick;
            end
            S_DATA: begin
                w_cnt_clr  = w_bit_tick;
                w_shift_en = w_bit_tick;
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                w_cnt_clr = w_bit_tick;
                w_par_set = w_bit_tick & ((^r_shift) ^ r_rx_s);
            end
`endif
            S_STOP: begin
                w_cnt_clr   = w_bit_tick;
`ifdef UART_RX_PARITY_EN
                w_push      = w_bit_tick & r_rx_s & ~r_par_bad;
`else
                w_push      = w_bit_tick & r_rx_s;
`endif
                w_frame_set = w_bit_tick & ~r_rx_s;
            end
            S_BREAK: begin
                w_cnt_clr = 1'b1;
            end
            default: begin
                w_cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : (r_cnt + CNT_ONE);
            if (r_state != S_DATA) begin
                r_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    // LSB arrives first, so shift in from the top.
    always_ff @(posedge wb_clk_i) begin
        if (w_shift_en) begin
            r_shift <= {r_rx_s, r_shift[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Remembers a bad parity bit until the STOP decision for this frame.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_par_bad <= 1'b0;
        end else if (w_par_set) begin
            r_par_bad <= 1'b1;
        end else if (r_state == S_IDLE) begin
            r_par_bad <= 1'b0;
        end
    end
`endif

    // ---------------------------------------------------------------------
    // RX FIFO
    // ---------------------------------------------------------------------
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;
    logic             w_pop;
    logic             w_full;
    logic             w_wr;
    logic             w_ovr_set;

    assign w_pop     = rx_valid & rx_ready;
    assign w_full    = (r_level == LVL_FULL);
    // A simultaneous pop frees the head slot, so a push while full still fits.
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_ovr_set = w_push & w_full & ~w_pop;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    assign rx_data  = r_mem[r_rd_ptr];
    assign rx_valid = (r_level != '0);
    assign rx_level = r_level;
    assign irq      = rx_valid;

    // ---------------------------------------------------------------------
    // Sticky error flags; a set event wins over a coincident clear
    // ---------------------------------------------------------------------
    logic r_frame_err;
    logic r_overrun;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

`ifdef UART_RX_PARITY_EN
    logic r_parity_err;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_parity_err <= 1'b0;
        end else if (w_par_set) begin
            r_parity_err <= 1'b1;
        end else if (err_clr) begin
            r_parity_err <= 1'b0;
        end
    end

    assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 5;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 10;
`else
    localparam int FRAME_BITS = 9;
`endif
    // 2 sync + 1 edge + half bit + remaining bits + 1 push cycle
    localparam int EXP_LAT = 3 + CPB / 2 + FRAME_BITS * CPB + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic       rx_ready;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] rx_level;
    logic       frame_err;
    logic       overrun;
    logic       irq;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_core #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .CNT_W        (CW)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .rx_i       (rx_i),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_level   (rx_level),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;
    int last_pop_cyc = -1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every accepted byte is compared with the queue head.
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
                n_vec++;
                last_pop_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pop: got %02h, expected no byte", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        n_err++;
                        $display("FAIL pop_data: got %02h, expected %02h", rx_data, e);
                    end
                end
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx_i = ^b;
        tick(CPB);
`endif
        rx_i = stop_v;
        tick(CPB);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_badpar(input logic [7:0] b);
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            tick(CPB);
        end
        rx_i = ~(^b);
        tick(CPB);
        rx_i = 1'b1;
        tick(CPB);
    endtask
`endif

    initial begin
        int start_cyc;
        int lat;
        logic [7:0] part;

        rst      = 1'b1;
        rx_i     = 1'b1;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        fork
            monitor();
        join_none
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        check("rst_valid", int'(rx_valid), 0);
        check("rst_level", int'(rx_level), 0);
        check("rst_data", int'(rx_data), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_irq", int'(irq), 0);

        // Single byte with the consumer always ready
        rx_ready = 1'b1;
        tick(4);
        exp_q.push_back(8'h3D);
        start_cyc = cyc;
        send_frame(8'h3D, 1'b1);
        tick(2);
        lat = last_pop_cyc - start_cyc;
        check("latency_in_window", int'(lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1), 1);
        check("t1_level", int'(rx_level), 0);
        check("t1_frame_err", int'(frame_err), 0);
        check("t1_overrun", int'(overrun), 0);

        // Three back-to-back bytes buffered, then drained in order
        rx_ready = 1'b0;
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hFF);
        send_frame(8'h0A, 1'b1);
        check("t2_level1", int'(rx_level), 1);
        check("t2_head", int'(rx_data), 8'h0A);
        send_frame(8'h55, 1'b1);
        check("t2_level2", int'(rx_level), 2);
        send_frame(8'hFF, 1'b1);
        check("t2_level3", int'(rx_level), 3);
        check("t2_irq_set", int'(irq), 1);
        rx_ready = 1'b1;
        tick(5);
        rx_ready = 1'b0;
        check("t2_level0", int'(rx_level), 0);
        check("t2_irq_clear", int'(irq), 0);

        // Overrun: five bytes into a four-entry FIFO
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        check("t3_level_full", int'(rx_level), 4);
        check("t3_overrun_set", int'(overrun), 1);
        check("t3_head", int'(rx_data), 8'h01);
        check("t3_frame_err", int'(frame_err), 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("t3_overrun_clr", int'(overrun), 0);
        check("t3_level_kept", int'(rx_level), 4);
        rx_ready = 1'b1;
        tick(6);
        rx_ready = 1'b0;
        check("t3_drained", int'(rx_level), 0);

        // Framing error followed by a held-low line
        send_frame(8'hA5, 1'b0);
        rx_i = 1'b0;
        tick(30 * CPB);
        check("t4_no_push", int'(rx_level), 0);
        check("t4_frame_err", int'(frame_err), 1);
        check("t4_overrun", int'(overrun), 0);
        rx_i = 1'b1;
        tick(2 * CPB);
        check("t4_no_push_release", int'(rx_level), 0);
        rx_ready = 1'b1;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        tick(2);
        rx_ready = 1'b0;
        check("t4_frame_err_sticky", int'(frame_err), 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("t4_frame_err_clr", int'(frame_err), 0);

        // Short low glitch must not start a frame
        rx_i = 1'b0;
        tick(3);
        rx_i = 1'b1;
        tick(3 * CPB);
        check("t5_glitch_level", int'(rx_level), 0);
        check("t5_glitch_frame_err", int'(frame_err), 0);
        check("t5_glitch_overrun", int'(overrun), 0);

        // Reset mid-frame with a byte held in the FIFO
        send_frame(8'h77, 1'b1);
        check("t5_held_level", int'(rx_level), 1);
        part = 8'h81;
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx_i = part[i];
            tick(CPB);
        end
        rx_i = 1'b1;
        rst  = 1'b1;
        tick(2);
        rst  = 1'b0;
        tick(1);
        check("t5_rst_level", int'(rx_level), 0);
        check("t5_rst_valid", int'(rx_valid), 0);
        check("t5_rst_data", int'(rx_data), 0);
        tick(4 * CPB);
        check("t5_rst_quiet", int'(rx_level), 0);
        rx_ready = 1'b1;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        tick(2);
        check("t5_after_rst_level", int'(rx_level), 0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x3D has five ones, so the parity bit must be 1
        exp_q.push_back(8'h3D);
        send_frame(8'h3D, 1'b1);
        tick(2);
        check("t6_par_ok", int'(parity_err), 0);
        send_frame_badpar(8'h3D);
        tick(2);
        check("t6_par_err", int'(parity_err), 1);
        check("t6_par_no_push", int'(rx_level), 0);
        check("t6_par_frame_err", int'(frame_err), 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("t6_par_clr", int'(parity_err), 0);
`endif

        rx_ready = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
